// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC and fetches one instruction at a time over req/gnt/rvalid, handing it to decode.
// Latency: REQ, WAIT and VALID take one cycle each at best, so 3 cycles per instruction; gnt/rvalid stalls add 1 cycle each.
// Backpressure: decode holds instr_ready_i low and the instruction and PC are held in VALID; a misaligned redirect halts fetch until reset.
module instr_fetch_unit #(
  parameter int                   DataWidth   = 32,
  parameter logic [DataWidth-1:0] ResetVector = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pc_src_sel_i,
  input  logic [DataWidth-1:0] pc_target_i,
  output logic                 imem_req_o,
  output logic [DataWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [DataWidth-1:0] instr_o,
  output logic [DataWidth-1:0] pc_o,
  output logic [DataWidth-1:0] pc_plus4_o,
  output logic                 fetch_fault_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, FAULT} state_t;

  state_t               state;
  logic [DataWidth-1:0] pc_q;
  logic [DataWidth-1:0] instr_q;
  logic [DataWidth-1:0] pc_plus4;
  logic [DataWidth-1:0] next_pc;
  logic                 req_q;
  logic                 valid_q;
  logic                 fault_q;

  // Sequential successor and redirect choice; only consumed on the decode handshake.
  always_comb begin
    pc_plus4 = pc_q + DataWidth'(4);
    next_pc  = pc_src_sel_i ? pc_target_i : pc_plus4;
  end

  // Fetch FSM; req/valid/fault flags are registered alongside the state so no input reaches an output combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      pc_q    <= ResetVector;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          // Address is pc_q, which cannot change until this fetch completes.
          if (imem_gnt_i) begin
            state <= WAIT;
            req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            instr_q <= imem_rdata_i;
            state   <= VALID;
            valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (instr_ready_i) begin
            valid_q <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              // Misaligned target: keep the old PC and stop fetching for good.
              state   <= FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q  <= next_pc;
              state <= REQ;
              req_q <= 1'b1;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a memory model answers fetches and a queue holds the
// instruction/PC pair each granted fetch should deliver to decode.
module tb_instr_fetch_unit;

  logic        clk_i;
  logic        rst_ni;
  logic        pc_src_sel_i;
  logic [31:0] pc_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_fault_o;

  instr_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pc_src_sel_i  (pc_src_sel_i),
    .pc_target_i   (pc_target_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .fetch_fault_o (fetch_fault_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Hard stop in case the DUT wedges somewhere no bounded wait covers.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One fetch: wait for req, withhold gnt, grant, delay rvalid, return data.
  task automatic fetch_one(input logic [31:0] exp_addr, input int gnt_dly, input int rv_dly,
                           output int req_cyc);
    int n;
    n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'b0, imem_req_o}, 32'd1);
    req_cyc = cyc;
    check("req_addr", imem_addr_o, exp_addr);
    for (int i = 0; i < gnt_dly; i++) begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b1;              // must be ignored outside WAIT
      imem_rdata_i  = 32'hDEAD_BEEF;
      tick();
      check("req_hold", {31'b0, imem_req_o}, 32'd1);
      check("addr_hold", imem_addr_o, exp_addr);
    end
    imem_rvalid_i = 1'b0;
    imem_gnt_i    = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
    sb.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
    check("req_drop", {31'b0, imem_req_o}, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      tick();
      check("valid_early", {31'b0, instr_valid_o}, 32'd0);
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = mem_word(exp_addr);
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hBAD0_0000;
    check("valid_rise", {31'b0, instr_valid_o}, 32'd1);
  endtask

  // Compare the presented instruction to the scoreboard, stall decode, then accept with a redirect choice.
  task automatic accept(input int hold, input logic sel, input logic [31:0] tgt);
    exp_t e;
    n_tests++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed %0d entries expected at least 1", sb.size());
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("pc_o", pc_o, e.pc);
    check("instr_o", instr_o, e.instr);
    check("pc_plus4", pc_plus4_o, e.pc + 32'd4);
    for (int i = 0; i < hold; i++) begin
      instr_ready_i = 1'b0;
      pc_src_sel_i  = 1'b1;              // must be ignored without a handshake
      pc_target_i   = 32'h0000_0003;
      tick();
      check("bp_valid", {31'b0, instr_valid_o}, 32'd1);
      check("bp_instr", instr_o, e.instr);
      check("bp_pc", pc_o, e.pc);
    end
    instr_ready_i = 1'b1;
    pc_src_sel_i  = sel;
    pc_target_i   = tgt;
    tick();
    instr_ready_i = 1'b0;
    pc_src_sel_i  = 1'b0;
    pc_target_i   = 32'hFFFF_FFFF;
    check("valid_drop", {31'b0, instr_valid_o}, 32'd0);
  endtask

  initial begin
    int c0, c1, c2, c, rel;
    rst_ni        = 1'b0;
    pc_src_sel_i  = 1'b0;
    pc_target_i   = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_fault", {31'b0, fetch_fault_o}, 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_pc4", pc_plus4_o, 32'h4);
    check("rst_addr", imem_addr_o, 32'h0);

    // Reset release: IDLE for one cycle, req in the 2nd cycle
    rst_ni = 1'b1;
    rel = cyc;
    check("idle_no_req", {31'b0, imem_req_o}, 32'd0);
    fetch_one(32'h0, 0, 0, c0);
    check("first_req_cycle", c0 - rel, 32'd1);
    check("first_valid_lat", cyc - c0, 32'd2);
    accept(0, 1'b0, 32'h0);

    // Sequential fetch at 3-cycle spacing
    fetch_one(32'h4, 0, 0, c1);
    check("spacing_4", c1 - c0, 32'd3);
    accept(0, 1'b0, 32'h0);
    fetch_one(32'h8, 0, 0, c2);
    check("spacing_8", c2 - c1, 32'd3);
    accept(0, 1'b1, 32'h100);

    // Redirect, then backpressure for 5 cycles
    fetch_one(32'h100, 0, 0, c);
    accept(5, 1'b0, 32'h0);

    // Stalled grant (3) and rvalid (4)
    fetch_one(32'h104, 3, 4, c);
    accept(0, 1'b1, 32'hFFFF_FFFC);

    // Wrap-around of PC+4
    fetch_one(32'hFFFF_FFFC, 0, 0, c);
    accept(0, 1'b0, 32'h0);

    // Misaligned target -> absorbing fault
    fetch_one(32'h0, 0, 0, c);
    accept(0, 1'b1, 32'h102);
    check("fault_set", {31'b0, fetch_fault_o}, 32'd1);
    check("fault_pc_kept", pc_o, 32'h0);
    for (int i = 0; i < 8; i++) begin
      imem_gnt_i = 1'b1;
      instr_ready_i = 1'b1;
      tick();
      check("fault_no_req", {31'b0, imem_req_o}, 32'd0);
      check("fault_no_valid", {31'b0, instr_valid_o}, 32'd0);
      check("fault_sticky", {31'b0, fetch_fault_o}, 32'd1);
    end
    imem_gnt_i = 1'b0;
    instr_ready_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("fault_cleared", {31'b0, fetch_fault_o}, 32'd0);
    sb.delete();
    tick();
    rst_ni = 1'b1;

    // Reset mid-read, then a stale rvalid in IDLE
    tick();
    check("mr_req", {31'b0, imem_req_o}, 32'd1);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    check("mr_wait", {31'b0, imem_req_o}, 32'd0);
    rst_ni = 1'b0;
    #1;
    check("mr_rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("mr_rst_pc", pc_o, 32'h0);
    check("mr_rst_instr", instr_o, 32'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h5151_5151;
    tick();
    imem_rvalid_i = 1'b0;
    check("stale_no_valid", {31'b0, instr_valid_o}, 32'd0);
    check("stale_no_capture", instr_o, 32'h0);
    fetch_one(32'h0, 0, 1, c);
    accept(0, 1'b0, 32'h0);
    check("restart_next", imem_addr_o, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Owns the architectural program counter and fetches one instruction at a time from instruction memory over a req/gnt/rvalid bus.
- Presents the instruction and its PC to decode through a valid/ready handshake.
- Sits directly upstream of the control-flow unit: it consumes that unit's `pc_src_sel` / `pc_target` pair to pick the next PC when decode accepts an instruction.
- Detects misaligned redirect targets and halts fetch with a fault flag.

## Interface

**Parameters**
- `DataWidth`, default 32: width of PC, addresses and instruction words.
- `ResetVector`, default 32'h0000_0000: PC of the first fetch after reset.

**Ports** (name, direction, width, meaning)
- `clk_i`, input, 1: the only clock. All state changes on its rising edge.
- `rst_ni`, input, 1: reset, **asynchronous, active-low**.
- `pc_src_sel_i`, input, 1: from the control-flow unit. 1 means take `pc_target_i`, 0 means PC+4.
- `pc_target_i`, input, DataWidth: redirect target from the control-flow unit.
- `imem_req_o`, output, 1: fetch request.
- `imem_addr_o`, output, DataWidth: fetch address (always the current PC).
- `imem_gnt_i`, input, 1: memory accepted the request.
- `imem_rvalid_i`, input, 1: read data valid.
- `imem_rdata_i`, input, DataWidth: fetched instruction word.
- `instr_valid_o`, output, 1: instruction is available to decode.
- `instr_ready_i`, input, 1: decode accepts the instruction.
- `instr_o`, output, DataWidth: captured instruction.
- `pc_o`, output, DataWidth: PC of `instr_o`.
- `pc_plus4_o`, output, DataWidth: `pc_o` + 4, modulo 2^DataWidth.
- `fetch_fault_o`, output, 1: a misaligned redirect target was seen; fetch is halted.

## Operation

**FSM states:** IDLE, REQ, WAIT, VALID, FAULT. Reset state is IDLE.

- **IDLE**
  - No request is issued.
  - Unconditionally goes to REQ on the next cycle.
- **REQ**
  - `imem_req_o`=1 and `imem_addr_o`=PC.
  - If `imem_gnt_i`=1, go to WAIT; otherwise stay in REQ.
  - Address is held stable until granted.
- **WAIT**
  - `imem_req_o`=0.
  - On `imem_rvalid_i`=1, capture `imem_rdata_i` into `instr_o` and go to VALID.
  - `rvalid` can arrive at the earliest one cycle after the gnt cycle. There is no timeout.
- **VALID**
  - `instr_valid_o`=1. `instr_o`, `pc_o` and `pc_plus4_o` are held constant while `instr_ready_i`=0.
  - On handshake (`valid` and `ready` both 1), compute next = `pc_src_sel_i` ? `pc_target_i` : PC+4.
  - If next[1:0]≠0: PC is not updated, go to FAULT.
  - Otherwise: PC ← next, go to REQ.
  - `pc_src_sel_i` and `pc_target_i` are sampled only in the handshake cycle and ignored at all other times.
- **FAULT**
  - Absorbing state: `fetch_fault_o`=1, no requests, `instr_valid_o`=0.
  - Left only by reset.

**Other rules**
- `imem_rvalid_i` and `imem_rdata_i` are ignored outside WAIT.
- `imem_gnt_i` is ignored outside REQ.
- PC+4 wraps modulo 2^DataWidth; no overflow flag.
- PC[1:0] is always 00, since ResetVector must be word-aligned.
- `pc_plus4_o` is a combinational function of the PC register.

## Timing

**Reset values** (while `rst_ni`=0):
- state IDLE, PC = ResetVector
- `imem_req_o`=0, `instr_valid_o`=0, `fetch_fault_o`=0
- `instr_o`=0
- `pc_o`=ResetVector, `pc_plus4_o`=ResetVector+4
- `imem_addr_o`=ResetVector

**Reset behaviour**
- Reset asserted in any state, including WAIT with a read outstanding, forces the values above immediately.
- An `rvalid` arriving after reset is released, while in IDLE or REQ, is discarded.

**Latency and throughput**
- First request is issued in the 2nd cycle after `rst_ni` rises (IDLE lasts exactly 1 cycle).
- With gnt in the request cycle, rvalid the next cycle, and ready held high: REQ, WAIT and VALID each take 1 cycle, i.e. 3 cycles per instruction.
- Every gnt delay or rvalid delay cycle adds 1 cycle per instruction.

**Output timing**
- All outputs are registered or decoded from state/PC only.
- No combinational path from `instr_ready_i` or from any `imem_*` input to any output.

## Test plan

1. **Reset release.** Release reset with gnt tied high and rvalid one cycle later. Required:
   - `imem_req_o` rises in the 2nd cycle with addr 0x0.
   - `instr_valid_o` rises 2 cycles later with `pc_o`=0x0 and `instr_o`=rdata.
2. **Sequential fetch.** `pc_src_sel_i`=0 and ready=1. Required:
   - Fetch addresses are 0x0, 0x4, 0x8 at 3-cycle spacing.
   - `pc_plus4_o` equals `pc_o`+4 for each instruction.
3. **Redirect and backpressure.** At the handshake of the instruction at 0x8, drive sel=1 and target=0x100. Required:
   - Next request addr is 0x100.
   - Holding ready=0 for 5 cycles keeps `instr_o` and `pc_o` stable with valid=1.
4. **Stalled grant and rvalid.**
   - gnt withheld 3 cycles: addr stays stable and req stays high for 4 cycles.
   - rvalid delayed 4 cycles: valid rises exactly 1 cycle after rvalid.
5. **Misaligned target and wrap-around.**
   - Target 0x102 at handshake: `fetch_fault_o`=1 next cycle, no further req ever, and reset clears it.
   - A PC of 0xFFFF_FFFC with sel=0 gives a next fetch at 0x0.
6. **Reset mid-read.** Assert reset in WAIT, deassert, then inject a stale rvalid in IDLE. Required:
   - The stale rvalid is ignored.
   - Fetch restarts at ResetVector.
